// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: FSM encodings, port ids and
// the RISC-V load/store funct3 size codes understood by data_memory.
package dmem_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_t;

  // Load size/sign codes
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  // Store size codes
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

endpackage

// File: rtl/dmem_arbiter_arb.sv
// Winner select with port-0 priority plus a starvation counter that hands
// the next contended arbitration to port 1 after STARVE_LIMIT port-0 wins.
module arb_prio_starve
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req0,
  input  logic             i_req1,
  input  logic             i_arb,
  output port_t            o_winner,
  output logic [CNT_W-1:0] o_starve_cnt
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_starved;

  assign w_starved    = (r_cnt >= CNT_W'(STARVE_LIMIT));
  assign o_starve_cnt = r_cnt;

  // Port 1 wins when alone or when port 0 has starved it long enough.
  always_comb begin
    o_winner = PORT0;
    if (i_req1 && (!i_req0 || w_starved)) o_winner = PORT1;
  end

  // Count consecutive port-0 wins taken while port 1 was waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_arb) begin
      if ((o_winner == PORT1) || !i_req1) begin
        r_cnt <= '0;
      end else if (r_cnt != {CNT_W{1'b1}}) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory. A request is
// arbitrated in IDLE, performed in a one-cycle ACCESS phase (gnt pulse) and
// read data is returned through a registered rvalid/rdata pair one cycle
// later.
//
// Handshake: a requester raises req with a stable payload and holds both
// until it sees gnt; gnt is a single-cycle pulse in the cycle the memory
// access happens. A read answers with a single-cycle rvalid in the following
// cycle; rdata then holds until the next read on that port. Writes give no
// rvalid.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [31:0]      m0_addr,
  input  logic [31:0]      m0_wdata,
  input  logic [2:0]       m0_funct3,
  output logic             m0_gnt,
  output logic             m0_rvalid,
  output logic [31:0]      m0_rdata,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [31:0]      m1_addr,
  input  logic [31:0]      m1_wdata,
  input  logic [2:0]       m1_funct3,
  output logic             m1_gnt,
  output logic             m1_rvalid,
  output logic [31:0]      m1_rdata,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [2:0]       mem_funct3,
  input  logic [31:0]      mem_rdata,
  output state_t           o_dbg_state,
  output logic [CNT_W-1:0] o_dbg_starve_cnt
);

  state_t      r_state;
  state_t      w_next_state;
  logic        w_load;
  port_t       w_winner;
  logic        w_access;

  port_t       r_id;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;

  logic        r_rvalid0;
  logic        r_rvalid1;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;

  arb_prio_starve #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_arb (
    .clk          (clk),
    .rst          (rst),
    .i_req0       (m0_req),
    .i_req1       (m1_req),
    .i_arb        (w_load),
    .o_winner     (w_winner),
    .o_starve_cnt (o_dbg_starve_cnt)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next state: arbitrate in IDLE, always leave ACCESS after one cycle.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          w_load       = 1'b1;
          w_next_state = ST_ACCESS;
        end
      end
      ST_ACCESS: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Latch the winner's payload at arbitration; held until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id     <= PORT0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_funct3 <= '0;
    end else if (w_load) begin
      r_id <= w_winner;
      if (w_winner == PORT1) begin
        r_we     <= m1_we;
        r_addr   <= m1_addr;
        r_wdata  <= m1_wdata;
        r_funct3 <= m1_funct3;
      end else begin
        r_we     <= m0_we;
        r_addr   <= m0_addr;
        r_wdata  <= m0_wdata;
        r_funct3 <= m0_funct3;
      end
    end
  end

  // rst gates the access phase so an aborted write never reaches memory.
  assign w_access   = (r_state == ST_ACCESS) && !rst;
  assign mem_we     = w_access && r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign mem_funct3 = r_funct3;
  assign m0_gnt     = w_access && (r_id == PORT0);
  assign m1_gnt     = w_access && (r_id == PORT1);

  // Capture read data at the end of ACCESS and flag it for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= m0_gnt && !r_we;
      r_rvalid1 <= m1_gnt && !r_we;
      if (m0_gnt && !r_we) r_rdata0 <= mem_rdata;
      if (m1_gnt && !r_we) r_rdata1 <= mem_rdata;
    end
  end

  assign m0_rvalid   = r_rvalid0;
  assign m1_rvalid   = r_rvalid1;
  assign m0_rdata    = r_rdata0;
  assign m1_rdata    = r_rdata1;
  assign o_dbg_state = r_state;

endmodule
